// File: rtl/score_history_reader.sv
// Read-side companion to the score writer: scans the regfile score slots, computes
// best and truncated-average reaction time, then lets a button browse the stored scores.
module score_history_reader #(
    parameter int WIDTH     = 13,
    parameter int NUM_SLOTS = 7,
    parameter int ADDR_W    = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              buttonNext,
    input  logic [WIDTH-1:0]  RunCount,
    input  logic [WIDTH-1:0]  ReadData,
    output logic [ADDR_W-1:0] ReadAddr,
    output logic [WIDTH-1:0]  ShowValue,
    output logic [3:0]        ShowIndex,
    output logic [WIDTH-1:0]  BestScore,
    output logic [WIDTH-1:0]  AvgScore,
    output logic              Busy,
    output logic              Done
);

    localparam int SUM_W = WIDTH + 3;
    localparam int CNT_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DIVIDE, BROWSE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   show_value_q, show_value_d;
    logic [3:0]         show_index_q, show_index_d;
    logic [WIDTH-1:0]   best_q, best_d;
    logic [WIDTH-1:0]   avg_q, avg_d;
    logic [WIDTH-1:0]   min_q, min_d;
    logic [SUM_W-1:0]   sum_q, sum_d;   // running sum, then dividend/quotient shift register
    logic [SUM_W-1:0]   rem_q, rem_d;
    logic [3:0]         n_q, n_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               btn_q;

    logic [3:0]         n_eff;
    logic               btn_rise;
    logic [3:0]         index_inc;
    logic [SUM_W-1:0]   rem_shift;
    logic [SUM_W-1:0]   quot_shift;

    assign n_eff     = (RunCount > WIDTH'(NUM_SLOTS)) ? 4'(NUM_SLOTS) : RunCount[3:0];
    assign btn_rise  = buttonNext & ~btn_q;
    assign index_inc = (show_index_q == n_q) ? 4'd1 : show_index_q + 4'd1;
    assign rem_shift  = {rem_q[SUM_W-2:0], sum_q[SUM_W-1]};
    assign quot_shift = {sum_q[SUM_W-2:0], 1'b0};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        show_value_d = show_value_q;
        show_index_d = show_index_q;
        best_d       = best_q;
        avg_d        = avg_q;
        min_d        = min_q;
        sum_d        = sum_q;
        rem_d        = rem_q;
        n_d          = n_q;
        bit_cnt_d    = bit_cnt_q;

        case (state_q)
            IDLE, BROWSE: begin
                if (state_q == BROWSE) begin
                    show_value_d = ReadData;
                    if (btn_rise && n_q != 4'd0) begin
                        show_index_d = index_inc;
                        addr_d       = ADDR_W'(index_inc);
                    end
                end
                // Start is evaluated last so it overrides a simultaneous button step.
                if (Start) begin
                    n_d = n_eff;
                    if (n_eff == 4'd0) begin
                        state_d      = BROWSE;
                        best_d       = '0;
                        avg_d        = '0;
                        show_value_d = '0;
                        show_index_d = 4'd0;
                        addr_d       = '0;
                    end else begin
                        state_d = SCAN;
                        addr_d  = ADDR_W'(1);
                        sum_d   = '0;
                        min_d   = '1;
                    end
                end
            end

            SCAN: begin
                sum_d = sum_q + SUM_W'(ReadData);
                min_d = (ReadData < min_q) ? ReadData : min_q;
                if (4'(addr_q) == n_q) begin
                    state_d   = DIVIDE;
                    rem_d     = '0;
                    bit_cnt_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            DIVIDE: begin
                if (bit_cnt_q == CNT_W'(SUM_W)) begin
                    best_d       = min_q;
                    avg_d        = (|sum_q[SUM_W-1:WIDTH]) ? '1 : sum_q[WIDTH-1:0];
                    addr_d       = ADDR_W'(1);
                    show_index_d = 4'd1;
                    state_d      = BROWSE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (rem_shift >= SUM_W'(n_q)) begin
                        rem_d = rem_shift - SUM_W'(n_q);
                        sum_d = quot_shift | SUM_W'(1);
                    end else begin
                        rem_d = rem_shift;
                        sum_d = quot_shift;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            show_value_q <= '0;
            show_index_q <= 4'd0;
            best_q       <= '0;
            avg_q        <= '0;
            min_q        <= '0;
            sum_q        <= '0;
            rem_q        <= '0;
            n_q          <= 4'd0;
            bit_cnt_q    <= '0;
            btn_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            show_value_q <= show_value_d;
            show_index_q <= show_index_d;
            best_q       <= best_d;
            avg_q        <= avg_d;
            min_q        <= min_d;
            sum_q        <= sum_d;
            rem_q        <= rem_d;
            n_q          <= n_d;
            bit_cnt_q    <= bit_cnt_d;
            btn_q        <= buttonNext;
        end
    end

    assign ReadAddr  = addr_q;
    assign ShowValue = show_value_q;
    assign ShowIndex = show_index_q;
    assign BestScore = best_q;
    assign AvgScore  = avg_q;
    assign Busy      = (state_q == SCAN) || (state_q == DIVIDE);
    assign Done      = (state_q == BROWSE);

endmodule

// File: doc/score_history_reader.md
Name: score_history_reader

Overview:
Read-side companion to the game FSM's score writer. It walks the register file's score slots through the read port (RQ/DATAQ), computing best (minimum) and truncated-average reaction time over the stored runs. It then enters a browse mode in which a button steps through individual stored scores for the seven-segment displays. It uses only the regfile read port Q and never drives a write.

Parameters:
WIDTH, 13, score/data width; matches regfile data width
NUM_SLOTS, 7, score slots at regfile addresses 1..NUM_SLOTS; address 0 holds run count
ADDR_W, 3, regfile address width

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  synchronous pulse; begins a scan (ignored while Busy)
buttonNext  input  1  synchronous level; a rising edge detected internally advances the browse index
RunCount  input  WIDTH  run count, taken from regfile address 0 (DATAP)
ReadData  input  WIDTH  regfile DATAQ; combinational function of ReadAddr
ReadAddr  output  ADDR_W  registered; drives regfile RQ
ShowValue  output  WIDTH  registered score of the currently browsed slot
ShowIndex  output  4  currently browsed slot number (0 = none)
BestScore  output  WIDTH  minimum score over valid slots
AvgScore  output  WIDTH  floor(sum/count)
Busy  output  1  high in SCAN and DIVIDE
Done  output  1  high in BROWSE

Behaviour:
- Reset (async): state IDLE; all outputs 0; buttonNext edge-detect register cleared.
- Effective count: n = min(RunCount, NUM_SLOTS), evaluated when Start is sampled in IDLE or BROWSE.
- IDLE/BROWSE, Start=1:
  - If n=0: go to BROWSE. Best=Avg=ShowValue=ShowIndex=ReadAddr=0.
  - Else: ReadAddr<=1, clear sum (WIDTH+3 bits), best<=all-ones, go to SCAN.
- SCAN, one edge per slot: sample ReadData at current ReadAddr k.
  - sum += ReadData; best = min(best, ReadData).
  - If k<n: ReadAddr<=k+1. If k=n: go to DIVIDE.
- DIVIDE: restoring division sum/n, one quotient bit per edge, WIDTH+3 = 16 edges.
  - Quotient truncated to WIDTH bits; saturate to all-ones on overflow, which is unreachable with valid inputs.
  - On completion: latch BestScore and AvgScore, ReadAddr<=1, ShowIndex<=1, go to BROWSE.
- Latency: Done rises exactly n+17 edges after the edge sampling Start (1 setup + n scan + 16 divide).
- BestScore/AvgScore hold previous values until the new scan completes; they are never partially updated.
- BROWSE:
  - Every edge: ShowValue<=ReadData.
  - Rising edge of buttonNext: ShowIndex/ReadAddr increment; wraps from n to 1.
  - With n=0, buttonNext is ignored.
  - ShowValue reflects the new slot one edge after the index changes.
- Start while Busy is ignored. Start in BROWSE restarts the scan with a fresh n and deasserts Done the next edge.
- buttonNext outside BROWSE: the edge-detect register still tracks the input, but the press has no effect (no queued steps).
- Simultaneous Start and buttonNext edge in BROWSE: Start wins.
- RunCount and ReadData changing mid-scan are sampled as-is; consistency is the writer's responsibility.
- Reset mid-SCAN or mid-DIVIDE: immediate return to IDLE with all outputs 0.

Test Plan:
- Regfile model: addr0=3, slots 1..3 = 100, 250, 175; pulse Start -> Busy for 20 edges, Done at edge 20, BestScore=100, AvgScore=175, ShowIndex=1, ShowValue=100 one edge later.
- addr0=2, slots 7, 8 -> AvgScore=7 (truncated), BestScore=7, Done at edge 19.
- addr0=9, slots 1..7 = 10..70 -> clamped n=7, sum 280, AvgScore=40, BestScore=10, Done at edge 24.
- addr0=0, Start -> Done next edge, Best=Avg=ShowIndex=0; buttonNext presses leave all outputs unchanged.
- After the 3-slot scan, press buttonNext 3 times (held multiple cycles each) -> ShowIndex 2, 3, 1; ShowValue 250, 175, 100; Start pulsed during SCAN is ignored.
- Assert Reset on the 2nd SCAN edge -> all outputs 0 immediately, state IDLE; a new Start then completes normally with the same results.
